// File: rtl/rv_alu_seq.sv
// rv_alu_seq: single-cycle RV ALU with an iterative restoring divider.
// Define RV_ALU_SEQ_MUL_EN to add the 2-stage MUL/MULH/MULHSU/MULHU path.
package pkg_rv_decode;
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_S2     = 5'd2,  ALU_SLT   = 5'd3,
    ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_OR     = 5'd6,  ALU_AND   = 5'd7,
    ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA    = 5'd10, ALU_CSR   = 5'd11,
    ALU_DIV  = 5'd12, ALU_DIVU = 5'd13, ALU_REM    = 5'd14, ALU_REMU  = 5'd15,
    ALU_MUL  = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19
  } alu_t;
endpackage

// state | meaning
// IDLE  | accepting ops, single-cycle results only
// ITER  | one restoring divide step per cycle
// DONE  | latched result on rwdat, cmpl high until rdy
module rv_alu_seq
  import pkg_rv_decode::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            xreset,
  input  logic            rdy,
  input  logic            start,
  input  alu_t            alu,
  input  logic [XLEN-1:0] rrd1,
  input  logic [XLEN-1:0] rrd2,
  input  logic [XLEN-1:0] csr_rd,
  output logic [XLEN-1:0] rwdat,
  output logic            busy,
  output logic            cmpl,
  output logic            mulop
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  alu_t            op_q, op_d;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] single_res, done_res, q_fix, r_fix, a_mag, b_mag;
  logic            is_div, is_sdiv, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN:0]   shl, trial;

  assign shamt = rrd2[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (alu)
      ALU_ADD:  single_res = rrd1 + rrd2;
      ALU_SUB:  single_res = rrd1 - rrd2;
      ALU_S2:   single_res = rrd2;
      ALU_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(rrd1) < $signed(rrd2))};
      ALU_SLTU: single_res = {{(XLEN-1){1'b0}}, (rrd1 < rrd2)};
      ALU_XOR:  single_res = rrd1 ^ rrd2;
      ALU_OR:   single_res = rrd1 | rrd2;
      ALU_AND:  single_res = rrd1 & rrd2;
      ALU_SLL:  single_res = rrd1 << shamt;
      ALU_SRL:  single_res = rrd1 >> shamt;
      ALU_SRA:  single_res = $signed(rrd1) >>> shamt;
      ALU_CSR:  single_res = csr_rd;
      default:  single_res = '0;
    endcase
  end

  assign is_div   = (alu == ALU_DIV) || (alu == ALU_DIVU) || (alu == ALU_REM) || (alu == ALU_REMU);
  assign is_sdiv  = (alu == ALU_DIV) || (alu == ALU_REM);
  assign a_neg    = is_sdiv & rrd1[XLEN-1];
  assign b_neg    = is_sdiv & rrd2[XLEN-1];
  assign a_mag    = a_neg ? -rrd1 : rrd1;
  assign b_mag    = b_neg ? -rrd2 : rrd2;
  assign div_zero = (rrd2 == '0);
  assign div_ovf  = is_sdiv && (rrd1 == {1'b1, {(XLEN-1){1'b0}}}) && (rrd2 == '1);

  // trial[XLEN] set means the shifted remainder is below the divisor
  assign shl   = {rem_q, quo_q[XLEN-1]};
  assign trial = shl - {1'b0, dvs_q};

`ifdef RV_ALU_SEQ_MUL_EN
  logic              is_mul;
  logic [2*XLEN-1:0] ma, mb, prod;
  assign is_mul = (alu == ALU_MUL) || (alu == ALU_MULH) || (alu == ALU_MULHSU) || (alu == ALU_MULHU);
  assign ma = ((alu == ALU_MULH) || (alu == ALU_MULHSU)) ? {{XLEN{rrd1[XLEN-1]}}, rrd1} : {{XLEN{1'b0}}, rrd1};
  assign mb = (alu == ALU_MULH) ? {{XLEN{rrd2[XLEN-1]}}, rrd2} : {{XLEN{1'b0}}, rrd2};
  assign prod = ma * mb;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    op_d    = op_q;
    mulop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && is_div) begin
          mulop  = xreset;
          op_d   = alu;
          negq_d = 1'b0;
          negr_d = 1'b0;
          if (div_zero) begin
            quo_d   = '1;
            rem_d   = rrd1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            quo_d   = {1'b1, {(XLEN-1){1'b0}}};
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = SHW'(XLEN-1);
            state_d = S_ITER;
          end
        end
`ifdef RV_ALU_SEQ_MUL_EN
        else if (start && is_mul) begin
          mulop          = xreset;
          op_d           = alu;
          negq_d         = 1'b0;
          negr_d         = 1'b0;
          {rem_d, quo_d} = prod;
          state_d        = S_DONE;
        end
`endif
      end
      S_ITER: begin
        if (trial[XLEN]) begin
          rem_d = shl[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: if (rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  always_comb begin
    done_res = '0;
    case (op_q)
      ALU_DIV, ALU_DIVU: done_res = q_fix;
      ALU_REM, ALU_REMU: done_res = r_fix;
`ifdef RV_ALU_SEQ_MUL_EN
      ALU_MUL:                          done_res = quo_q;
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  done_res = rem_q;
`endif
      default: done_res = '0;
    endcase
  end

  assign rwdat = (state_q == S_DONE) ? done_res : single_res;
  assign busy  = (state_q != S_IDLE);
  assign cmpl  = (state_q == S_DONE);

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      op_q    <= ALU_ADD;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      op_q    <= op_d;
    end
  end

endmodule
